mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit.sv | 146 ++++++++++++++
 tb/tb_mdu_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Multi-cycle mult/div with fixed latency; mthi/mtlo complete in one edge.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDURead1,
   input  logic [31:0] MDURead2,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;

   logic [0:0]       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             busy_next;
   logic [31:0]      hi_q, lo_q, hi_next, lo_next;
   logic [31:0]      a_q, b_q;
   logic [3:0]       op_q;
   logic             latch;

   logic [63:0] prod_u, prod_s;
   logic [31:0] a_abs, b_abs, b_abs_safe, b_safe;
   logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
   logic        a_neg, b_neg;

   // Result datapath, evaluated from the latched operands only
   always_comb begin
      prod_u     = {32'b0, a_q} * {32'b0, b_q};
      prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      a_neg      = a_q[31];
      b_neg      = b_q[31];
      a_abs      = a_neg ? (~a_q + 32'd1) : a_q;
      b_abs      = b_neg ? (~b_q + 32'd1) : b_q;
      // divisor of zero never reaches HI/LO; substitute 1 to keep the divider defined
      b_abs_safe = (b_abs == 32'd0) ? 32'd1 : b_abs;
      b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
      uq_s       = a_abs / b_abs_safe;
      ur_s       = a_abs % b_abs_safe;
      q_s        = (a_neg ^ b_neg) ? (~uq_s + 32'd1) : uq_s;
      r_s        = a_neg ? (~ur_s + 32'd1) : ur_s;
      q_u        = a_q / b_safe;
      r_u        = a_q % b_safe;
   end

   // Next-state, counter and HI/LO update
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      hi_next    = hi_q;
      lo_next    = lo_q;
      latch      = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) begin
               case (MDUOp)
                  OP_MULT, OP_MULTU: begin
                     latch      = 1'b1;
                     cnt_next   = CNT_W'(MULT_CYCLES);
                     state_next = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     latch      = 1'b1;
                     cnt_next   = CNT_W'(DIV_CYCLES);
                     state_next = S_BUSY;
                  end
                  OP_MTHI: hi_next = MDURead1;
                  OP_MTLO: lo_next = MDURead1;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               cnt_next   = '0;
               state_next = S_IDLE;
               case (op_q)
                  OP_MULT:  {hi_next, lo_next} = prod_s;
                  OP_MULTU: {hi_next, lo_next} = prod_u;
                  OP_DIV: begin
                     if (b_q != 32'd0) begin
                        hi_next = r_s;
                        lo_next = q_s;
                     end
                  end
                  OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        hi_next = r_u;
                        lo_next = q_u;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_next = S_IDLE;
      endcase
      busy_next = (state_next == S_BUSY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         Busy  <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         Busy  <= busy_next;
         hi_q  <= hi_next;
         lo_q  <= lo_next;
         if (latch) begin
            a_q  <= MDURead1;
            b_q  <= MDURead2;
            op_q <= MDUOp;
         end
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against an arithmetic HI/LO model.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] MDURead1, MDURead2;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDURead1(MDURead1), .MDURead2(MDURead2),
      .MDUOp(MDUOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int latency(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return 5;
      if (op == 4'd3 || op == 4'd4) return 10;
      return 0;
   endfunction

   // Architectural effect of one operation on HI/LO
   task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd2: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
         4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
         default: ;
      endcase
   endtask

   // Issue one request; mode 1 injects ignored requests and operand changes while busy
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
      logic [31:0] hi0, lo0;
      int n, exp_n;
      hi0   = m_hi;
      lo0   = m_lo;
      exp_n = latency(op);
      @(negedge clk);
      MDUOp = op; MDURead1 = a; MDURead2 = b; Start = 1'b1;
      model_op(op, a, b);
      @(posedge clk); #1;
      Start = 1'b0;
      if (exp_n == 0) begin
         check("mt_busy", 64'(Busy), 64'd0);
         check("mt_hi", 64'(HI), 64'(m_hi));
         check("mt_lo", 64'(LO), 64'(m_lo));
         return;
      end
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         check("hold_hi", 64'(HI), 64'(hi0));
         check("hold_lo", 64'(LO), 64'(lo0));
         @(negedge clk);
         if (mode == 1) begin
            MDURead1 = $urandom;
            MDURead2 = $urandom;
            Start    = (n == 2 || n == 5 || n == exp_n);
            MDUOp    = (n == 2) ? 4'd6 : (n == 5) ? 4'd3 : 4'd5;
         end
         @(posedge clk); #1;
         Start = 1'b0;
      end
      check("busy_cycles", 64'(n), 64'(exp_n));
      check("res_hi", 64'(HI), 64'(m_hi));
      check("res_lo", 64'(LO), 64'(m_lo));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b0; Start = 1'b0; MDUOp = 4'd0; MDURead1 = 32'd0; MDURead2 = 32'd0;
      #12;
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_hi", 64'(HI), 64'd0);
      check("rst_lo", 64'(LO), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
      check("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFA);
      do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
      check("multu_hi", 64'(HI), 64'd1);
      check("multu_lo", 64'(LO), 64'h0000_0000_FFFF_FFFE);
      do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
      check("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
      do_op(4'd4, 32'd7, 32'd0, 0);
      check("divz_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
      check("divz_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("ovf_lo", 64'(LO), 64'h0000_0000_8000_0000);
      check("ovf_hi", 64'(HI), 64'd0);
      do_op(4'd5, 32'h1234_5678, 32'd0, 0);
      do_op(4'd6, 32'h9ABC_DEF0, 32'd0, 0);
      check("mthi_val", 64'(HI), 64'h0000_0000_1234_5678);
      check("mtlo_val", 64'(LO), 64'h0000_0000_9ABC_DEF0);
      do_op(4'd1, 32'h0001_0003, 32'hFFFF_0005, 1);
      do_op(4'd4, 32'hDEAD_BEEF, 32'd1234, 1);

      // Asynchronous reset in the middle of a divide
      do_op(4'd5, 32'hDEAD_0001, 32'd0, 0);
      @(negedge clk);
      MDUOp = 4'd3; MDURead1 = 32'd100; MDURead2 = 32'd7; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", 64'(Busy), 64'd0);
      check("arst_hi", 64'(HI), 64'd0);
      check("arst_lo", 64'(LO), 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("post_busy", 64'(Busy), 64'd0);
      check("post_hi", 64'(HI), 64'd0);
      check("post_lo", 64'(LO), 64'd0);

      for (int i = 0; i < 60; i++)
         do_op(4'($urandom_range(0, 7)), pick(), pick(), int'($urandom_range(0, 1)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
